// File: rtl/aes128_sched.sv
// AES-128 job scheduler: arbitrates two client request ports onto a single AES
// datapath core, one job in flight at a time, and presents the core result on a
// valid/ready result port.
//
// Ports:
//   i_clk, i_rst            rising-edge clock, synchronous active-high reset
//   i_key_ok                expanded key valid; gates acceptance of new jobs
//   i_cX_valid/o_cX_ready   client X request handshake (X = 0, 1)
//   i_cX_flag, i_cX_data    client X mode (1 = encrypt) and 128-bit block
//   o_core_flag             mode to the core
//   o_core_din, _din_en     block and one-cycle start pulse to the core
//   i_core_dout, _dout_en   core result and completion strobe
//   o_res_valid/i_res_ready result handshake
//   o_res_data/_id/_flag    result block, originating client, mode
//   o_busy                  high whenever not idle
//   o_err                   sticky protocol error (cleared only by reset)
//   o_done_cnt              completed-job counter, wraps
module aes128_sched (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_key_ok,
  input  logic         i_c0_valid,
  output logic         o_c0_ready,
  input  logic         i_c0_flag,
  input  logic [127:0] i_c0_data,
  input  logic         i_c1_valid,
  output logic         o_c1_ready,
  input  logic         i_c1_flag,
  input  logic [127:0] i_c1_data,
  output logic         o_core_flag,
  output logic [127:0] o_core_din,
  output logic         o_core_din_en,
  input  logic [127:0] i_core_dout,
  input  logic         i_core_dout_en,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [127:0] o_res_data,
  output logic         o_res_id,
  output logic         o_res_flag,
  output logic         o_busy,
  output logic         o_err,
  output logic [15:0]  o_done_cnt
);

  // RUN is entered one cycle after ISSUE with the counter at 0, so a count of 10
  // with no strobe means 11 cycles have passed since ISSUE; the job is dropped on
  // that edge and the error is visible 12 cycles after ISSUE.
  localparam logic [3:0] TimeoutCnt = 4'd10;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StHold} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  job_data_q;
  logic          job_flag_q;
  logic          job_id_q;
  logic          core_flag_q;
  logic [127:0]  res_data_q;
  logic          res_id_q;
  logic          res_flag_q;
  logic          err_q;
  logic [15:0]   done_q;
  logic          last_q;  // client granted most recently

  logic pick1, can_accept, gnt0, gnt1, accept, err_set, capture, res_fire;

  // Round-robin: on a tie the client not granted last wins.
  assign pick1      = i_c1_valid & (~i_c0_valid | ~last_q);
  assign can_accept = (state_q == StIdle) & i_key_ok & ~i_rst;
  assign gnt0       = can_accept & i_c0_valid & ~pick1;
  assign gnt1       = can_accept & i_c1_valid & pick1;
  assign accept     = gnt0 | gnt1;
  assign capture    = (state_q == StRun) & i_core_dout_en;
  assign res_fire   = (state_q == StHold) & i_res_ready;

  // Strobe outside RUN is spurious; RUN reaching the limit means the core hung.
  assign err_set = (i_core_dout_en & (state_q != StRun)) |
                   ((state_q == StRun) & ~i_core_dout_en & (cnt_q == TimeoutCnt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
      StRun: begin
        cnt_d = cnt_q + 4'd1;
        if (i_core_dout_en)            state_d = StHold;
        else if (cnt_q == TimeoutCnt)  state_d = StIdle;
      end
      StHold: begin
        if (i_res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      job_data_q  <= '0;
      job_flag_q  <= 1'b0;
      job_id_q    <= 1'b0;
      core_flag_q <= 1'b1;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_flag_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 16'd0;
      last_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        job_data_q  <= gnt1 ? i_c1_data : i_c0_data;
        job_flag_q  <= gnt1 ? i_c1_flag : i_c0_flag;
        job_id_q    <= gnt1;
        core_flag_q <= gnt1 ? i_c1_flag : i_c0_flag;
        last_q      <= gnt1;
      end
      if (capture) begin
        res_data_q <= i_core_dout;
        res_id_q   <= job_id_q;
        res_flag_q <= job_flag_q;
      end
      if (err_set)  err_q  <= 1'b1;
      if (res_fire) done_q <= done_q + 16'd1;
    end
  end

  assign o_c0_ready    = gnt0;
  assign o_c1_ready    = gnt1;
  assign o_core_flag   = core_flag_q;
  assign o_core_din    = job_data_q;
  assign o_core_din_en = (state_q == StIssue);
  assign o_res_valid   = (state_q == StHold);
  assign o_res_data    = res_data_q;
  assign o_res_id      = res_id_q;
  assign o_res_flag    = res_flag_q;
  assign o_busy        = (state_q != StIdle);
  assign o_err         = err_q;
  assign o_done_cnt    = done_q;

endmodule

// File: tb/tb_aes128_sched.sv
// Self-checking bench for aes128_sched: directed scenarios followed by randomized
// jobs, checked against a transaction-level model of arbitration, timing and result.
module tb_aes128_sched;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_key_ok;
  logic         i_c0_valid, i_c1_valid, i_c0_flag, i_c1_flag;
  logic [127:0] i_c0_data, i_c1_data;
  logic         o_c0_ready, o_c1_ready;
  logic         o_core_flag, o_core_din_en;
  logic [127:0] o_core_din;
  logic [127:0] i_core_dout;
  logic         i_core_dout_en;
  logic         o_res_valid, i_res_ready;
  logic [127:0] o_res_data;
  logic         o_res_id, o_res_flag, o_busy, o_err;
  logic [15:0]  o_done_cnt;

  aes128_sched dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_key_ok       (i_key_ok),
    .i_c0_valid     (i_c0_valid),
    .o_c0_ready     (o_c0_ready),
    .i_c0_flag      (i_c0_flag),
    .i_c0_data      (i_c0_data),
    .i_c1_valid     (i_c1_valid),
    .o_c1_ready     (o_c1_ready),
    .i_c1_flag      (i_c1_flag),
    .i_c1_data      (i_c1_data),
    .o_core_flag    (o_core_flag),
    .o_core_din     (o_core_din),
    .o_core_din_en  (o_core_din_en),
    .i_core_dout    (i_core_dout),
    .i_core_dout_en (i_core_dout_en),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_res_data     (o_res_data),
    .o_res_id       (o_res_id),
    .o_res_flag     (o_res_flag),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_done_cnt     (o_done_cnt)
  );

  always #5 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_gnt;     // model: client granted last
  logic err_model;
  int   done_model;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the AES core: any fixed, mode-dependent transform will do.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic f);
    logic [127:0] k;
    k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    return f ? (d ^ k) : {d[7:0], d[127:8]};
  endfunction

  task automatic clear_inputs();
    i_key_ok = 1'b1; i_c0_valid = 1'b0; i_c1_valid = 1'b0;
    i_core_dout_en = 1'b0; i_res_ready = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_c0_ready", o_c0_ready, 0);
    check_eq("rst_c1_ready", o_c1_ready, 0);
    check_eq("rst_din_en", o_core_din_en, 0);
    check_eq("rst_din", o_core_din, 0);
    check_eq("rst_core_flag", o_core_flag, 1);
    check_eq("rst_res_valid", o_res_valid, 0);
    check_eq("rst_res_data", o_res_data, 0);
    check_eq("rst_res_id", o_res_id, 0);
    check_eq("rst_res_flag", o_res_flag, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_err", o_err, 0);
    check_eq("rst_done", o_done_cnt, 0);
  endtask

  // Hold reset with requests pending so the ready gating is exercised too.
  task automatic do_reset();
    i_rst = 1'b1; i_key_ok = 1'b1; i_c0_valid = 1'b1; i_c1_valid = 1'b1;
    i_core_dout_en = 1'b0; i_res_ready = 1'b0;
    tick(); tick();
    check_reset_vals();
    i_c0_valid = 1'b0; i_c1_valid = 1'b0;
    i_rst = 1'b0;
    tick();
    last_gnt = 1'b1; err_model = 1'b0; done_model = 0;
  endtask

  // One full job from an IDLE cycle; returns in the IDLE cycle after it ends.
  task automatic run_job(input logic v0, input logic v1, input logic f0, input logic f1,
                         input logic [127:0] d0, input logic [127:0] d1,
                         input int bp, input bit respond);
    logic         exp_id, exp_flag;
    logic [127:0] exp_data, exp_res;
    exp_id   = (v0 && v1) ? ~last_gnt : v1;
    exp_flag = exp_id ? f1 : f0;
    exp_data = exp_id ? d1 : d0;
    exp_res  = core_fn(exp_data, exp_flag);
    i_key_ok = 1'b1; i_res_ready = 1'b0;
    i_c0_valid = v0; i_c1_valid = v1; i_c0_flag = f0; i_c1_flag = f1;
    i_c0_data = d0; i_c1_data = d1;
    #1;
    check_eq("grant_c0", o_c0_ready, !exp_id);
    check_eq("grant_c1", o_c1_ready, exp_id);
    last_gnt = exp_id;
    tick();  // A+1
    check_eq("issue_din_en", o_core_din_en, 1);
    check_eq("issue_din", o_core_din, exp_data);
    check_eq("issue_core_flag", o_core_flag, exp_flag);
    check_eq("issue_readies", {o_c0_ready, o_c1_ready}, 0);
    tick();  // A+2
    check_eq("run_din_en", o_core_din_en, 0);
    if (respond) begin
      repeat (8) tick();  // A+10
      i_core_dout_en = 1'b1; i_core_dout = exp_res;
      #1;
      check_eq("run_res_valid", o_res_valid, 0);
      tick();  // A+11
      i_core_dout_en = 1'b0; i_core_dout = rand128();
      check_eq("hold_res_valid", o_res_valid, 1);
      check_eq("hold_res_data", o_res_data, exp_res);
      check_eq("hold_res_id", o_res_id, exp_id);
      check_eq("hold_res_flag", o_res_flag, exp_flag);
      check_eq("hold_core_flag", o_core_flag, exp_flag);
      for (int i = 0; i < bp; i++) begin
        tick();
        check_eq("bp_res_valid", o_res_valid, 1);
        check_eq("bp_res_data", o_res_data, exp_res);
        check_eq("bp_readies", {o_c0_ready, o_c1_ready}, 0);
      end
      i_res_ready = 1'b1;
      tick();
      i_res_ready = 1'b0;
      done_model++;
      check_eq("done_cnt", o_done_cnt, 16'(done_model));
      check_eq("post_busy", o_busy, 0);
      check_eq("post_res_valid", o_res_valid, 0);
      check_eq("post_err", o_err, err_model);
    end else begin
      repeat (10) tick();  // A+12
      check_eq("to_busy_before", o_busy, 1);
      check_eq("to_err_before", o_err, err_model);
      tick();  // A+13 = ISSUE+12
      err_model = 1'b1;
      check_eq("to_err", o_err, 1);
      check_eq("to_busy", o_busy, 0);
      check_eq("to_res_valid", o_res_valid, 0);
      check_eq("to_done", o_done_cnt, 16'(done_model));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic         v0, v1;
    i_core_dout = '0; i_c0_data = '0; i_c1_data = '0; i_c0_flag = 1'b0; i_c1_flag = 1'b0;
    clear_inputs();
    do_reset();

    // Single job on client 0.
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    run_job(1, 0, 1, 0, d, '0, 0, 1);

    // Contention: both valid throughout, grants must alternate.
    do_reset();
    for (int i = 0; i < 4; i++) run_job(1, 1, i[0], ~i[0], rand128(), rand128(), 0, 1);

    // Backpressure for five cycles.
    run_job(0, 1, 0, 0, '0, rand128(), 5, 1);
    clear_inputs();

    // Missing strobe, then a normal job.
    run_job(1, 0, 1, 0, rand128(), '0, 0, 0);
    run_job(1, 0, 0, 0, rand128(), '0, 0, 1);
    clear_inputs();

    // Key gating and spurious strobe in IDLE.
    do_reset();
    i_key_ok = 1'b0; i_c1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("keygate_c1_ready", o_c1_ready, 0);
      tick();
      check_eq("keygate_busy", o_busy, 0);
    end
    i_c1_valid = 1'b0; i_key_ok = 1'b1;
    i_core_dout_en = 1'b1;
    tick();
    i_core_dout_en = 1'b0;
    check_eq("spurious_err", o_err, 1);
    check_eq("spurious_busy", o_busy, 0);

    // Reset during RUN discards the job; a late strobe is then an error.
    do_reset();
    i_c0_valid = 1'b1; i_c0_flag = 1'b0; i_c0_data = rand128();
    tick();
    i_c0_valid = 1'b0;
    repeat (3) tick();
    check_eq("midrun_busy", o_busy, 1);
    i_rst = 1'b1; i_c0_valid = 1'b1; i_c1_valid = 1'b1;
    tick();
    check_reset_vals();
    i_c0_valid = 1'b0; i_c1_valid = 1'b0; i_rst = 1'b0;
    tick();
    last_gnt = 1'b1; err_model = 1'b0; done_model = 0;
    i_core_dout_en = 1'b1;
    tick();
    i_core_dout_en = 1'b0;
    check_eq("late_strobe_err", o_err, 1);
    check_eq("late_strobe_res_valid", o_res_valid, 0);
    check_eq("late_strobe_done", o_done_cnt, 0);

    // Randomized jobs.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        i_key_ok = 1'b0;
        i_c0_valid = 1'($urandom); i_c1_valid = 1'($urandom);
        #1;
        check_eq("rnd_keygate", {o_c0_ready, o_c1_ready}, 0);
        tick();
        check_eq("rnd_keygate_busy", o_busy, 0);
      end
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      run_job(v0, v1, 1'($urandom), 1'($urandom), rand128(), rand128(),
              int'($urandom_range(0, 3)), $urandom_range(0, 9) != 0);
    end
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_sched.md
AES128_SCHED -- requirements
Module: aes128_sched

Interface
REQ-001 SHALL have i_clk  input  1  rising-edge clock; all state changes on it.
REQ-002 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have i_key_ok  input  1  expanded key valid; no new job accepted while low.
REQ-004 SHALL have i_c0_valid / o_c0_ready  input/output  1/1  client-0 request handshake.
REQ-005 SHALL have i_c0_flag  input  1  client-0 mode: 1=encrypt, 0=decrypt.
REQ-006 SHALL have i_c0_data  input  128  client-0 input block.
REQ-007 SHALL have i_c1_valid, o_c1_ready, i_c1_flag, i_c1_data  same widths and meaning as client 0.
REQ-008 SHALL have o_core_flag  output  1  mode driven to the AES datapath core.
REQ-009 SHALL have o_core_din / o_core_din_en  output  128/1  block and start pulse to the core.
REQ-010 SHALL have i_core_dout / i_core_dout_en  input  128/1  core result and completion strobe.
REQ-011 SHALL have o_res_valid / i_res_ready  output/input  1/1  result handshake.
REQ-012 SHALL have o_res_data / o_res_id / o_res_flag  output  128/1/1  result block, originating client, mode.
REQ-013 SHALL have o_busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have o_err  output  1  sticky protocol-error flag.
REQ-015 SHALL have o_done_cnt  output  16  completed-job counter.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> RUN -> HOLD -> IDLE; one job in flight max.
REQ-017 IDLE: o_cX_ready SHALL be combinational grant = i_key_ok & i_cX_valid & arbiter pick; at most one ready high per cycle; ready low in all other states.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant client not granted last; single valid -> grant it; after reset client 0 wins first tie.
REQ-019 On accept (valid&ready) SHALL register data, flag, id and enter ISSUE next cycle.
REQ-020 ISSUE SHALL drive o_core_din_en=1 for exactly one cycle with o_core_din = registered data, then enter RUN with internal counter cleared.
REQ-021 o_core_flag SHALL equal job flag from ISSUE until result captured, and SHALL hold its last value in IDLE/HOLD.
REQ-022 RUN: counter SHALL increment each cycle; core strobe expected 9 cycles after ISSUE cycle.
REQ-023 RUN: on i_core_dout_en SHALL capture i_core_dout, id, flag into result registers and enter HOLD.
REQ-024 RUN: if no strobe by 12 cycles after ISSUE, SHALL set o_err, drop the job (no result), return to IDLE.
REQ-025 HOLD: o_res_valid=1, result registers stable; on i_res_ready SHALL return to IDLE and increment o_done_cnt (wraps 0xFFFF->0x0000).
REQ-026 Latency: accept in cycle A -> din_en in A+1 -> core strobe A+10 -> o_res_valid A+11; next accept no earlier than cycle after result handshake.
REQ-027 i_core_dout_en in IDLE, ISSUE or HOLD SHALL set o_err and be otherwise ignored.
REQ-028 i_key_ok falling mid-job SHALL NOT abort the in-flight job; it only blocks later accepts.
REQ-029 o_err SHALL clear only on reset.

Reset
REQ-030 Reset SHALL force IDLE; o_cX_ready=0, o_core_din_en=0, o_core_din=0, o_core_flag=1, o_res_valid=0, o_res_data=0, o_res_id=0, o_res_flag=0, o_busy=0, o_err=0, o_done_cnt=0, arbiter pointer favours client 0.
REQ-031 Reset asserted mid-job SHALL discard the job; no result produced afterward.

Verification
REQ-032 Single job: c0 valid, flag=1, data=0x00112233_44556677_8899AABB_CCDDEEFF, key_ok=1, model core strobe at +9 -> din_en at A+1, o_res_valid at A+11, id=0, flag=1, done_cnt=1.
REQ-033 Contention: c0,c1 valid continuously, res_ready=1 -> grants alternate 0,1,0,1; four results ids 0,1,0,1.
REQ-034 Backpressure: res_ready low 5 cycles in HOLD -> o_res_valid stays 1, data stable, no ready to clients, then one handshake.
REQ-035 Missing strobe: core never responds -> o_err=1 at ISSUE+12, FSM IDLE, no o_res_valid, next job accepted normally.
REQ-036 Key gating and spurious strobe: key_ok=0 with c1 valid -> o_c1_ready stays 0; strobe in IDLE -> o_err=1.
REQ-037 Reset during RUN -> all outputs at REQ-030 values next cycle; later strobe from core sets o_err.
